// File: rtl/obi_to_axi_core.sv
// ============================================================================
//  Module   : obi_to_axi_core
//  Purpose  : Bridge from an OBI master to AXI4. Each granted OBI request
//             becomes one single-beat AXI read (AR+R) or write (AW+W+B).
//             Only one transaction is in flight at a time, and each one ends
//             with a single-cycle rvalid_o pulse.
//  Ports    : clk_i       - clock, rising edge
//             arst_i      - asynchronous active-high reset
//             addr_i      - OBI request address
//             we_i        - 1 = write, 0 = read
//             wdata_i     - OBI write data
//             be_i        - OBI byte enables
//             req_i       - OBI request
//             gnt_o       - OBI grant (combinational, idle only)
//             rvalid_o    - OBI response valid (reads and writes)
//             rdata_o     - OBI read data (0 for writes)
//             axi_req_o   - AXI master request struct
//             axi_resp_i  - AXI slave response struct
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_to_axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_USER_W = 1;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic [AXI_USER_W-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    axi_b_chan_t  b;
    logic         r_valid;
    axi_r_chan_t  r;
  } axi_resp_t;

endpackage

module obi_to_axi_core #(
  parameter int unsigned OBI_ADDRW = 32,
  parameter int unsigned OBI_DATAW = 32,
  parameter int unsigned OBI_STRBW = OBI_DATAW / 8,
  parameter type axi_req_t  = obi_to_axi_pkg::axi_req_t,
  parameter type axi_resp_t = obi_to_axi_pkg::axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [OBI_ADDRW-1:0] addr_i,
  input  logic                 we_i,
  input  logic [OBI_DATAW-1:0] wdata_i,
  input  logic [OBI_STRBW-1:0] be_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [OBI_DATAW-1:0] rdata_o,
  output axi_req_t             axi_req_o,
  input  axi_resp_t            axi_resp_i
);

  localparam logic [2:0] AX_SIZE    = 3'($clog2(OBI_STRBW));
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AWW  = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t                 state;
  axi_req_t               axi_req_q;
  logic                   rvalid_q;
  logic [OBI_DATAW-1:0]   rdata_q;

  // A channel counts as done once its valid has dropped or is handshaking now.
  logic aw_done;
  logic w_done;

  assign aw_done = ~axi_req_q.aw_valid | axi_resp_i.aw_ready;
  assign w_done  = ~axi_req_q.w_valid  | axi_resp_i.w_ready;

  // Grant is combinational in IDLE; masked during reset so every output is 0.
  assign gnt_o     = req_i & (state == IDLE) & ~arst_i;
  assign axi_req_o = axi_req_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;

  // Response fields the bridge deliberately ignores: errors are not
  // reported on OBI and IDs are always zero.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{axi_resp_i.b, axi_resp_i.r.id, axi_resp_i.r.resp,
                                axi_resp_i.r.last, axi_resp_i.r.user};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      axi_req_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            // Payload is latched into the outgoing struct so it stays
            // stable for as long as the valids are up.
            axi_req_q.ar.addr  <= addr_i;
            axi_req_q.ar.size  <= AX_SIZE;
            axi_req_q.ar.burst <= BURST_INCR;
            axi_req_q.aw.addr  <= addr_i;
            axi_req_q.aw.size  <= AX_SIZE;
            axi_req_q.aw.burst <= BURST_INCR;
            axi_req_q.w.data   <= wdata_i;
            axi_req_q.w.strb   <= be_i;
            axi_req_q.w.last   <= 1'b1;
            // Writes answer with zero data; reads overwrite this in R.
            rdata_q            <= '0;
            if (we_i) begin
              axi_req_q.aw_valid <= 1'b1;
              axi_req_q.w_valid  <= 1'b1;
              state              <= AWW;
            end else begin
              axi_req_q.ar_valid <= 1'b1;
              state              <= AR;
            end
          end
        end

        AR: begin
          if (axi_resp_i.ar_ready) begin
            axi_req_q.ar_valid <= 1'b0;
            axi_req_q.r_ready  <= 1'b1;
            state              <= R;
          end
        end

        R: begin
          if (axi_resp_i.r_valid) begin
            axi_req_q.r_ready <= 1'b0;
            rdata_q           <= axi_resp_i.r.data;
            rvalid_q          <= 1'b1;
            state             <= RESP;
          end
        end

        AWW: begin
          if (axi_resp_i.aw_ready) axi_req_q.aw_valid <= 1'b0;
          if (axi_resp_i.w_ready)  axi_req_q.w_valid  <= 1'b0;
          if (aw_done && w_done) begin
            axi_req_q.b_ready <= 1'b1;
            state             <= B;
          end
        end

        B: begin
          if (axi_resp_i.b_valid) begin
            axi_req_q.b_ready <= 1'b0;
            rvalid_q          <= 1'b1;
            state             <= RESP;
          end
        end

        RESP: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_to_axi_core.sv
// ============================================================================
//  Module   : tb_obi_to_axi_core
//  Purpose  : Self-checking bench for obi_to_axi_core. A transaction-level
//             model tracks which AXI channels of the current OBI request
//             are still pending and derives every expected output per cycle.
//             Directed scenarios pin the model with literal values; a
//             randomized phase drives random requests against a random slave.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_to_axi_core;
  import obi_to_axi_pkg::*;

  localparam int unsigned ADDRW = 32;
  localparam int unsigned DATAW = 32;
  localparam int unsigned STRBW = DATAW / 8;
  localparam logic [2:0]  EXP_SIZE = 3'($clog2(STRBW));

  logic             clk;
  logic             arst;
  logic [ADDRW-1:0] addr;
  logic             we;
  logic [DATAW-1:0] wdata;
  logic [STRBW-1:0] be;
  logic             req;
  logic             gnt;
  logic             rvalid;
  logic [DATAW-1:0] rdata;
  axi_req_t         axi_req;
  axi_resp_t        axi_resp;

  // Slave behaviour knobs (written by main only)
  logic        rand_mode;
  int          ar_stall, aw_stall, w_stall;
  logic        b_hold;
  logic [31:0] zero_rdata;

  // Literal expectations (written by main only)
  logic        lit_en;
  logic [31:0] lit_addr, lit_wdata, lit_rdata;
  logic [3:0]  lit_be;
  int          lit_lat;

  // Counters (written by compare only)
  int checks;
  int errors;
  int cyc;

  obi_to_axi_core #(
    .OBI_ADDRW (ADDRW),
    .OBI_DATAW (DATAW),
    .OBI_STRBW (STRBW),
    .axi_req_t (axi_req_t),
    .axi_resp_t(axi_resp_t)
  ) dut (
    .clk_i     (clk),
    .arst_i    (arst),
    .addr_i    (addr),
    .we_i      (we),
    .wdata_i   (wdata),
    .be_i      (be),
    .req_i     (req),
    .gnt_o     (gnt),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .axi_req_o (axi_req),
    .axi_resp_i(axi_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // AXI slave: stall counters count cycles a valid has waited unanswered.
  // --------------------------------------------------------------------------
  initial begin : slave
    int ar_wait, aw_wait, w_wait;
    ar_wait = 0; aw_wait = 0; w_wait = 0;
    axi_resp = '0;
    forever begin
      @(negedge clk);
      ar_wait = (axi_req.ar_valid && !axi_resp.ar_ready) ? ar_wait + 1 : 0;
      aw_wait = (axi_req.aw_valid && !axi_resp.aw_ready) ? aw_wait + 1 : 0;
      w_wait  = (axi_req.w_valid  && !axi_resp.w_ready)  ? w_wait  + 1 : 0;
      @(posedge clk);
      #1;
      if (rand_mode) begin
        axi_resp.ar_ready = ($urandom_range(0, 3) != 0);
        axi_resp.aw_ready = ($urandom_range(0, 3) != 0);
        axi_resp.w_ready  = ($urandom_range(0, 3) != 0);
        axi_resp.r_valid  = ($urandom_range(0, 2) != 0);
        axi_resp.b_valid  = ($urandom_range(0, 2) != 0);
        axi_resp.r.data   = $urandom;
      end else begin
        axi_resp.ar_ready = (ar_wait >= ar_stall);
        axi_resp.aw_ready = (aw_wait >= aw_stall);
        axi_resp.w_ready  = (w_wait  >= w_stall);
        axi_resp.r_valid  = 1'b1;
        axi_resp.b_valid  = !b_hold;
        axi_resp.r.data   = zero_rdata;
      end
      // Fields the bridge must ignore get noise.
      axi_resp.r.resp = 2'($urandom);
      axi_resp.r.id   = 4'($urandom);
      axi_resp.r.last = 1'($urandom);
      axi_resp.b.resp = 2'($urandom);
      axi_resp.b.id   = 4'($urandom);
    end
  end

  // --------------------------------------------------------------------------
  // Model + compare: one outstanding OBI transaction, with per-channel
  // "done" flags; outputs follow from which channels are still pending.
  // --------------------------------------------------------------------------
  initial begin : compare
    logic         act, t_we, ar_d, aw_d, w_d, rs_d;
    logic [31:0]  t_addr, t_wdata, t_rdata;
    logic [3:0]   t_be;
    int           g_cyc;
    logic         exp_gnt, exp_rv;
    logic [4:0]   exp_hs, got_hs;
    axi_ar_chan_t e_ar;
    axi_aw_chan_t e_aw;
    axi_w_chan_t  e_w;
    act = 0; t_we = 0; ar_d = 0; aw_d = 0; w_d = 0; rs_d = 0;
    t_addr = 0; t_wdata = 0; t_rdata = 0; t_be = 0; g_cyc = 0;
    checks = 0; errors = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (arst) begin
        check("rst_gnt", gnt, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_axi_req", axi_req, 0);
        act = 0;
      end else begin
        exp_gnt = req && !act;
        exp_rv  = act && rs_d;
        exp_hs  = {act && !t_we && !ar_d,
                   act && !t_we && ar_d && !rs_d,
                   act && t_we && !aw_d,
                   act && t_we && !w_d,
                   act && t_we && aw_d && w_d && !rs_d};
        got_hs  = {axi_req.ar_valid, axi_req.r_ready, axi_req.aw_valid,
                   axi_req.w_valid, axi_req.b_ready};
        check("gnt", gnt, exp_gnt);
        check("rvalid", rvalid, exp_rv);
        check("valid_ready", got_hs, exp_hs);

        if (exp_rv) begin
          check("rdata", rdata, t_rdata);
          if (lit_en) begin
            check("lit_rdata", rdata, lit_rdata);
            if (lit_lat != 0) check("lit_latency", cyc - g_cyc, lit_lat);
          end
        end
        if (exp_hs[4]) begin
          e_ar = '0; e_ar.addr = t_addr; e_ar.size = EXP_SIZE; e_ar.burst = 2'b01;
          check("ar_payload", axi_req.ar, e_ar);
          if (lit_en) begin
            check("lit_ar_addr", axi_req.ar.addr, lit_addr);
            check("lit_ar_len", axi_req.ar.len, 0);
            check("lit_ar_size", axi_req.ar.size, 2);
          end
        end
        if (exp_hs[2]) begin
          e_aw = '0; e_aw.addr = t_addr; e_aw.size = EXP_SIZE; e_aw.burst = 2'b01;
          check("aw_payload", axi_req.aw, e_aw);
          if (lit_en) check("lit_aw_addr", axi_req.aw.addr, lit_addr);
        end
        if (exp_hs[1]) begin
          e_w = '0; e_w.data = t_wdata; e_w.strb = t_be; e_w.last = 1'b1;
          check("w_payload", axi_req.w, e_w);
          if (lit_en) begin
            check("lit_w_data", axi_req.w.data, lit_wdata);
            check("lit_w_strb", axi_req.w.strb, lit_be);
            check("lit_w_last", axi_req.w.last, 1);
          end
        end

        // Advance the model with the handshakes seen this cycle.
        if (act && rs_d) begin
          act = 0;
        end else if (act) begin
          if (exp_hs[4] && axi_resp.ar_ready) ar_d = 1;
          if (exp_hs[3] && axi_resp.r_valid) begin rs_d = 1; t_rdata = axi_resp.r.data; end
          if (exp_hs[2] && axi_resp.aw_ready) aw_d = 1;
          if (exp_hs[1] && axi_resp.w_ready)  w_d  = 1;
          if (exp_hs[0] && axi_resp.b_valid) begin rs_d = 1; t_rdata = 0; end
        end else if (exp_gnt) begin
          act = 1; t_we = we; t_addr = addr; t_wdata = wdata; t_be = be;
          ar_d = 0; aw_d = 0; w_d = 0; rs_d = 0; g_cyc = cyc;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // OBI master helpers (called at posedge+1, return at posedge+1)
  // --------------------------------------------------------------------------
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    logic g;
    int   n;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    g = 1'b0; n = 0;
    while (!g && n < 1000) begin
      @(negedge clk);
      g = gnt;
      n++;
      @(posedge clk);
      #1;
    end
    if (!g) begin
      $display("FAIL grant_wait: got no grant required grant within 1000 cycles");
      $fatal(1, "grant timeout");
    end
    // Scramble the bus after the grant: the bridge must use latched values.
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
  endtask

  task automatic wait_rvalid();
    logic seen;
    int   n;
    seen = 1'b0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = rvalid;
      n++;
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      $display("FAIL rvalid_wait: got no pulse required rvalid within 200 cycles");
      $fatal(1, "rvalid timeout");
    end
  endtask

  task automatic wait_bready();
    logic seen;
    int   n;
    seen = 1'b0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = axi_req.b_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      $display("FAIL bready_wait: got no b_ready required b_ready within 200 cycles");
      $fatal(1, "b_ready timeout");
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    arst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    rand_mode = 1'b0; ar_stall = 0; aw_stall = 0; w_stall = 0; b_hold = 1'b0;
    zero_rdata = '0;
    lit_en = 1'b0; lit_addr = '0; lit_wdata = '0; lit_rdata = '0; lit_be = '0; lit_lat = 0;

    #700;
    @(posedge clk);
    #1;
    arst = 1'b0;
    idle_cycles(2);

    // Zero-wait read
    zero_rdata = 32'h45;
    lit_en = 1'b1; lit_addr = 32'hAB; lit_rdata = 32'h45; lit_lat = 3;
    do_txn(1'b0, 32'hAB, 32'h0, 4'hF);
    wait_rvalid();
    lit_en = 1'b0;

    // Zero-wait write
    lit_en = 1'b1; lit_addr = 32'hAB; lit_wdata = 32'h69; lit_be = 4'hF;
    lit_rdata = 32'h0; lit_lat = 3;
    do_txn(1'b1, 32'hAB, 32'h69, 4'hF);
    wait_rvalid();
    lit_en = 1'b0;

    // AR backpressure: 5 stalled cycles
    ar_stall = 5; zero_rdata = 32'hDEAD_BEEF;
    lit_en = 1'b1; lit_addr = 32'h100; lit_rdata = 32'hDEAD_BEEF; lit_lat = 8;
    do_txn(1'b0, 32'h100, 32'h0, 4'hF);
    wait_rvalid();
    lit_en = 1'b0; ar_stall = 0;

    // W ready 4 cycles after AW handshake
    w_stall = 4;
    lit_en = 1'b1; lit_addr = 32'h200; lit_wdata = 32'h1234; lit_be = 4'h3;
    lit_rdata = 32'h0; lit_lat = 7;
    do_txn(1'b1, 32'h200, 32'h1234, 4'h3);
    wait_rvalid();
    lit_en = 1'b0; w_stall = 0;

    // Back-to-back, each request held until granted
    zero_rdata = 32'h5A;
    do_txn(1'b0, 32'h10, 32'h0,  4'hF);
    do_txn(1'b1, 32'h14, 32'h69, 4'hF);
    do_txn(1'b0, 32'h18, 32'h0,  4'hF);
    do_txn(1'b1, 32'h1C, 32'h78, 4'hC);
    do_txn(1'b1, 32'h20, 32'hFC, 4'h1);
    wait_rvalid();
    idle_cycles(2);

    // Reset while waiting in B, then a normal read
    b_hold = 1'b1;
    do_txn(1'b1, 32'h30, 32'hAA, 4'hF);
    wait_bready();
    #1;
    arst = 1'b1;
    idle_cycles(3);
    arst = 1'b0;
    b_hold = 1'b0;
    zero_rdata = 32'h33;
    lit_en = 1'b1; lit_addr = 32'h40; lit_rdata = 32'h33; lit_lat = 3;
    do_txn(1'b0, 32'h40, 32'h0, 4'hF);
    wait_rvalid();
    lit_en = 1'b0;

    // Randomized traffic against a randomly stalling slave
    rand_mode = 1'b1;
    repeat (200) begin
      idle_cycles($urandom_range(0, 2));
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    rand_mode = 1'b0;
    idle_cycles(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
